// File: rtl/prim_edge_pkg.sv
// Edge-detector shared types.
// Edge modes and the mode-match helper.
package prim_edge_pkg;

  localparam int unsigned EdgeModeW = 2;

  typedef enum logic [EdgeModeW-1:0] {
    EdgeNone = 2'b00,
    EdgeRise = 2'b01,
    EdgeFall = 2'b10,
    EdgeBoth = 2'b11
  } edge_mode_e;

  function automatic logic edge_match(
    input edge_mode_e mode,
    input logic       r_edge,
    input logic       f_edge
  );
    logic hit;
    hit = 1'b0;
    unique case (mode)
      EdgeRise: hit = r_edge;
      EdgeFall: hit = f_edge;
      EdgeBoth: hit = r_edge | f_edge;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/prim_edge_filter.sv
// One channel: synchroniser, debounce, edges.
// Edges are registered alongside the filt update.
module prim_edge_filter #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FilterCntW = 4,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [FilterCntW-1:0] thresh_i,
  input  logic                  serial_i,
  output logic                  filt_o,
  output logic                  r_edge_o,
  output logic                  f_edge_o
);

  logic [SyncStages-1:0] stage_d;
  logic [SyncStages-1:0] stage_q;
  logic                  sync;
  logic                  mismatch;
  logic                  update;
  logic [FilterCntW-1:0] cnt_q;
  logic                  filt_q;

  assign stage_d = {stage_q[SyncStages-2:0], serial_i};

  for (genvar s = 0; s < SyncStages; s++) begin : g_sync
    prim_flop #(
      .Width      (1),
      .ResetValue (ResetValue)
    ) u_flop (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (stage_d[s]),
      .q_o    (stage_q[s])
    );
  end

  assign sync     = stage_q[SyncStages-1];
  assign mismatch = sync ^ filt_q;
  assign update   = mismatch & (cnt_q >= thresh_i);

  // Count consecutive mismatch cycles; never exceeds thresh.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                cnt_q <= '0;
    else if (!mismatch || update) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end

  // Filtered level and its en-gated edge pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q   <= ResetValue;
      r_edge_o <= 1'b0;
      f_edge_o <= 1'b0;
    end else begin
      if (update) filt_q <= sync;
      r_edge_o <= en_i & update & sync;
      f_edge_o <= en_i & update & ~sync;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/prim_flop.sv
// Plain resettable register.
// Building block for synchroniser chains.
module prim_flop #(
  parameter int unsigned     Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  // Capture d every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= ResetValue;
    else         q_o <= d_i;
  end

endmodule

// File: rtl/prim_edge_detect_multi.sv
// Multi-channel edge detector.
// Mode match, sticky W1C status, irq.
module prim_edge_detect_multi
  import prim_edge_pkg::*;
#(
  parameter int unsigned Width      = 4,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FilterCntW = 4,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [Width-1:0]      en_i,
  input  logic [2*Width-1:0]    mode_i,
  input  logic [FilterCntW-1:0] filt_thresh_i,
  input  logic [Width-1:0]      serial_i,
  input  logic [Width-1:0]      clr_i,
  output logic [Width-1:0]      filt_o,
  output logic [Width-1:0]      r_edge_o,
  output logic [Width-1:0]      f_edge_o,
  output logic [Width-1:0]      event_o,
  output logic [Width-1:0]      status_o,
  output logic                  irq_o
);

  logic [Width-1:0] status_q;

  for (genvar i = 0; i < Width; i++) begin : g_ch
    prim_edge_filter #(
      .SyncStages (SyncStages),
      .FilterCntW (FilterCntW),
      .ResetValue (ResetValue)
    ) u_filt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (en_i[i]),
      .thresh_i (filt_thresh_i),
      .serial_i (serial_i[i]),
      .filt_o   (filt_o[i]),
      .r_edge_o (r_edge_o[i]),
      .f_edge_o (f_edge_o[i])
    );
  end

  // Select which registered edges count as events.
  always_comb begin
    event_o = '0;
    for (int i = 0; i < Width; i++) begin
      event_o[i] = edge_match(edge_mode_e'(mode_i[2*i +: 2]),
                              r_edge_o[i], f_edge_o[i]);
    end
  end

  // Sticky flags; a new event beats a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) status_q <= '0;
    else         status_q <= (status_q & ~clr_i) | event_o;
  end

  assign status_o = status_q;
  assign irq_o    = |status_q;

endmodule

// File: tb/tb_prim_edge_detect_multi.sv
// Bench for prim_edge_detect_multi.
// Table vectors plus reset corner cases.
module tb_prim_edge_detect_multi;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [3:0] en, serial, clr, thr;
  logic [7:0] mode;
  logic [3:0] filt, r_edge, f_edge, ev, st;
  logic       irq;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] tag;
    logic [3:0]  ser, en, thr, clr;
    logic [7:0]  mode;
    logic [20:0] exp;
  } vec_t;

  vec_t        vecs[$];
  vec_t        post[$];
  logic [20:0] sb[$];

  always #5 clk = ~clk;

  prim_edge_detect_multi dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .en_i          (en),
    .mode_i        (mode),
    .filt_thresh_i (thr),
    .serial_i      (serial),
    .clr_i         (clr),
    .filt_o        (filt),
    .r_edge_o      (r_edge),
    .f_edge_o      (f_edge),
    .event_o       (ev),
    .status_o      (st),
    .irq_o         (irq)
  );

  function automatic vec_t mk(
    input logic [63:0] tag,
    input logic [3:0] s, e,
    input logic [7:0] m,
    input logic [3:0] t, c,
    input logic [3:0] xf, xr, xff, xe, xs,
    input logic xi
  );
    vec_t v;
    v.tag = tag; v.ser = s; v.en = e;
    v.mode = m; v.thr = t; v.clr = c;
    v.exp = {xf, xr, xff, xe, xs, xi};
    return v;
  endfunction

  task automatic check(input logic [63:0] tag,
                       input logic [20:0] want);
    logic [20:0] got;
    got = {filt, r_edge, f_edge, ev, st, irq};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got filt=%h r=%h f=%h ev=%h st=%h irq=%b want filt=%h r=%h f=%h ev=%h st=%h irq=%b",
               tag, got[20:17], got[16:13], got[12:9], got[8:5],
               got[4:1], got[0], want[20:17], want[16:13],
               want[12:9], want[8:5], want[4:1], want[0]);
    end
  endtask

  task automatic run_vec(input vec_t v);
    serial = v.ser; en = v.en; mode = v.mode;
    thr = v.thr; clr = v.clr;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    check(v.tag, sb.pop_front());
  endtask

  initial begin
    // reset / idle
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk("idle", 0, 4'hF, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0));
    // T=0 rise on ch0
    vecs.push_back(mk("t2_e0", 1, 4'hF, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t2_e1", 1, 4'hF, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t2_e2", 1, 4'hF, 8'hFF, 0, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk("t2_e3", 1, 4'hF, 8'hFF, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("t2_clr", 1, 4'hF, 8'hFF, 0, 1, 1, 0, 0, 0, 0, 0));
    // T=3 glitch then hold on ch1
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk("t3_glch", 3, 4'hF, 8'hFF, 3, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk("t3_gend", 1, 4'hF, 8'hFF, 3, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk("t3_hold", 3, 4'hF, 8'hFF, 3, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t3_edge", 3, 4'hF, 8'hFF, 3, 0, 3, 2, 0, 2, 0, 0));
    vecs.push_back(mk("t3_st", 3, 4'hF, 8'hFF, 3, 0, 3, 0, 0, 0, 2, 1));
    vecs.push_back(mk("t3_clr", 3, 4'hF, 8'hFF, 3, 2, 3, 0, 0, 0, 0, 0));
    // ch2 rises while disabled, then re-enable
    vecs.push_back(mk("t4_dis", 7, 4'hB, 8'hFF, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_dis", 7, 4'hB, 8'hFF, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_dis", 7, 4'hB, 8'hFF, 0, 0, 7, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_reen", 7, 4'hF, 8'hFF, 0, 0, 7, 0, 0, 0, 0, 0));
    // ch2 RISE mode sees a fall
    vecs.push_back(mk("t4_rise", 3, 4'hF, 8'hDF, 0, 0, 7, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_rise", 3, 4'hF, 8'hDF, 0, 0, 7, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_rise", 3, 4'hF, 8'hDF, 0, 0, 3, 0, 4, 0, 0, 0));
    vecs.push_back(mk("t4_rise", 3, 4'hF, 8'hDF, 0, 0, 3, 0, 0, 0, 0, 0));
    // ch2 FALL mode: rise ignored, fall counted
    vecs.push_back(mk("t4_fr", 7, 4'hF, 8'hEF, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_fr", 7, 4'hF, 8'hEF, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_fr", 7, 4'hF, 8'hEF, 0, 0, 7, 4, 0, 0, 0, 0));
    vecs.push_back(mk("t4_fr", 7, 4'hF, 8'hEF, 0, 0, 7, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_ff", 3, 4'hF, 8'hEF, 0, 0, 7, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_ff", 3, 4'hF, 8'hEF, 0, 0, 7, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_ff", 3, 4'hF, 8'hEF, 0, 0, 3, 0, 4, 4, 0, 0));
    vecs.push_back(mk("t4_ff", 3, 4'hF, 8'hEF, 0, 0, 3, 0, 0, 0, 4, 1));
    vecs.push_back(mk("t4_clr", 3, 4'hF, 8'hEF, 0, 4, 3, 0, 0, 0, 0, 0));
    // ch3: set-wins-over-clear
    vecs.push_back(mk("t5", 4'hB, 4'hF, 8'hFF, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t5", 4'hB, 4'hF, 8'hFF, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t5_rise", 3, 4'hF, 8'hFF, 0, 0, 4'hB, 8, 0, 8, 0, 0));
    vecs.push_back(mk("t5_st", 3, 4'hF, 8'hFF, 0, 0, 4'hB, 0, 0, 0, 8, 1));
    vecs.push_back(mk("t5_fall", 3, 4'hF, 8'hFF, 0, 0, 3, 0, 8, 8, 8, 1));
    vecs.push_back(mk("t5_setw", 3, 4'hF, 8'hFF, 0, 8, 3, 0, 0, 0, 8, 1));
    vecs.push_back(mk("t5_clr", 3, 4'hF, 8'hFF, 0, 8, 3, 0, 0, 0, 0, 0));
    // ch0 toggles while disabled
    vecs.push_back(mk("t6_dis", 2, 4'hE, 8'hFF, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t6_dis", 2, 4'hE, 8'hFF, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t6_dis", 2, 4'hE, 8'hFF, 0, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t6_dis", 3, 4'hE, 8'hFF, 0, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t6_dis", 3, 4'hE, 8'hFF, 0, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t6_dis", 3, 4'hE, 8'hFF, 0, 0, 3, 0, 0, 0, 0, 0));
    // ch1 fall sets status before the reset test
    vecs.push_back(mk("t6_f1", 1, 4'hF, 8'hFF, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t6_f1", 1, 4'hF, 8'hFF, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t6_f1", 1, 4'hF, 8'hFF, 0, 0, 1, 0, 2, 2, 0, 0));
    vecs.push_back(mk("t6_f1", 1, 4'hF, 8'hFF, 0, 0, 1, 0, 0, 0, 2, 1));
    // ch0 falls under T=5: still counting
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk("t6_cnt", 0, 4'hF, 8'hFF, 5, 0, 1, 0, 0, 0, 2, 1));
    // after release with input high: one edge
    post.push_back(mk("rel_e0", 1, 4'hF, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0));
    post.push_back(mk("rel_e1", 1, 4'hF, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0));
    post.push_back(mk("rel_e2", 1, 4'hF, 8'hFF, 0, 0, 1, 1, 0, 1, 0, 0));
    post.push_back(mk("rel_e3", 1, 4'hF, 8'hFF, 0, 0, 1, 0, 0, 0, 1, 1));
    post.push_back(mk("rel_e4", 1, 4'hF, 8'hFF, 0, 0, 1, 0, 0, 0, 1, 1));

    rst_ni = 1'b0;
    serial = '0; en = '0; mode = '0;
    thr = '0; clr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 21'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    foreach (vecs[k]) run_vec(vecs[k]);

    // async reset mid-count, between clock edges
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid", 21'h0);
    serial = 4'h1;
    thr = '0;
    @(negedge clk);
    rst_ni = 1'b1;

    foreach (post[k]) run_vec(post[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
